waveform_osc: RTL and testbench
===============================

// Module: waveform_osc
// PURPOSE
//  Parametrised multi-waveform tone generator; successor to the fixed 8-bit square oscillator.
//  A prescaler divides clk into phase ticks; a DATA_W-bit phase ramp drives square, variable-duty
//  pulse, sawtooth or triangle output. Feeds the audio mixer / PWM DAC path with unsigned samples.
// PARAMETERS
//  DATA_W  8   sample and phase width (>=2)
//  DIV_W   32  prescaler counter / div_max width
// PORTS
//  clk        in   1       system clock; single clock domain
//  rst        in   1       synchronous, active-high reset
//  en         in   1       1: run; 0: freeze div_cnt and phase (data holds)
//  sync       in   1       phase restart: div_cnt and phase cleared next edge
//  div_max    in   DIV_W   tick period = div_max+1 clk cycles
//  mode       in   2       waveform select (osc_pkg::WAVE_*)
//  duty       in   DATA_W  pulse threshold (mode PULSE only)
//  amplitude  in   DATA_W  output scale; port exists only with OSC_AMP_SCALE_EN
//  data       out  DATA_W  registered unsigned sample
//  wrap       out  1       1-cycle pulse when phase wraps MAX->0
// BEHAVIOUR
//  Reset: div_cnt=0, phase=0, data=0, wrap=0. rst overrides all other inputs.
//  Prescaler: tick = en & (div_cnt >= div_max). On tick div_cnt<=0, else if en div_cnt<=div_cnt+1.
//   '>=' compare: lowering div_max below current div_cnt gives a tick on the next enabled cycle.
//   div_max=0 -> tick every enabled cycle.
//  Phase: on tick phase<=phase+1 mod 2^DATA_W; wrap<=1 in the same edge when phase was all ones.
//  sync (priority over tick, below rst): div_cnt<=0, phase<=0, wrap<=0; data keeps normal pipeline.
//  Wave (combinational from phase, MAX = all ones):
//   WAVE_SQUARE 2'd0: phase[MSB]==0 ? MAX : 0 (starts high after reset/sync)
//   WAVE_PULSE  2'd1: phase < duty ? MAX : 0 (duty=0 -> always 0)
//   WAVE_SAW    2'd2: phase
//   WAVE_TRI    2'd3: t={phase[DATA_W-2:0],1'b0}; phase[MSB] ? ~t : t
//  Latency: data<=wave(phase) every clk (also when en=0); data lags phase by 1 cycle, a tick by 2.
//  mode/duty changes take effect on the next data update; phase not disturbed.
//  No handshake: consumer samples data at its own rate.
// CONFIGURATION
//  OSC_AMP_SCALE_EN defined: amplitude port present; data<=(wave*amplitude)>>DATA_W
//   (full 2*DATA_W product, truncate, no rounding); latency unchanged (single registered multiply).
//  Not defined: no amplitude port; data<=wave.
// STRUCTURE
//  osc_pkg: WAVE_SQUARE/PULSE/SAW/TRI localparams, MODE_W=2.
//  Sub-module osc_tick_divider (clk, rst, en, sync, div_max -> tick); phase, wave mux, output reg in top.
// TESTING (DATA_W=8, DIV_W=32, checker mirrors model cycle-by-cycle)
//  1 rst, SQUARE, div_max=0, en=1 -> data 0 for 1 cycle after rst, then FF x128 ticks, 00 x128; wrap every 256.
//  2 SAW, div_max=3 -> data +1 every 4 clks; FF->00 with one wrap pulse; en=0 -> data/phase frozen.
//  3 PULSE duty=40 -> FF for 64 ticks, 00 for 192; duty=00 -> constant 00; duty change mid-period honoured.
//  4 TRI, div_max=0 -> phase 00/7F/80/FF give data 00/FE/FF/01.
//  5 sync at div_cnt=2, phase=5A -> next cycle phase 00, div_cnt 0; div_max 10->2 at div_cnt=7 -> tick next cycle.
//  6 OSC_AMP_SCALE_EN, SAW: amplitude 80, phase FF -> data 7F; amplitude 00 -> 00; rst mid-run -> all outputs 0.

Source files
------------

// File: rtl/osc_pkg.sv
// Shared waveform-select encodings for the waveform_osc tone generator.
package osc_pkg;

    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] WAVE_SQUARE = 2'd0;
    localparam logic [MODE_W-1:0] WAVE_PULSE  = 2'd1;
    localparam logic [MODE_W-1:0] WAVE_SAW    = 2'd2;
    localparam logic [MODE_W-1:0] WAVE_TRI    = 2'd3;

endpackage

// File: rtl/osc_tick_divider.sv
// Prescaler: emits one phase tick every div_max+1 enabled clock cycles.
module osc_tick_divider #(
    parameter int unsigned DIV_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic [DIV_W-1:0] div_max,
    output logic             tick
);

    logic [DIV_W-1:0] div_cnt;

    // '>=' so that shrinking div_max below the running count ticks immediately.
    assign tick = en & (div_cnt >= div_max);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (sync || tick) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/waveform_osc.sv
// Multi-waveform tone generator: prescaled phase ramp -> square/pulse/saw/triangle sample.
// Optional output scaling by an amplitude port when OSC_AMP_SCALE_EN is defined.
module waveform_osc
    import osc_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sync,
    input  logic [DIV_W-1:0]  div_max,
    input  logic [MODE_W-1:0] mode,
    input  logic [DATA_W-1:0] duty,
`ifdef OSC_AMP_SCALE_EN
    input  logic [DATA_W-1:0] amplitude,
`endif
    output logic [DATA_W-1:0] data,
    output logic              wrap
);

    localparam logic [DATA_W-1:0] MAX = '1;

    logic              tick;
    logic [DATA_W-1:0] phase;
    logic [DATA_W-1:0] wave;
    logic [DATA_W-1:0] tri_t;
    logic [DATA_W-1:0] data_next;

    osc_tick_divider #(
        .DIV_W (DIV_W)
    ) u_tick_divider (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sync    (sync),
        .div_max (div_max),
        .tick    (tick)
    );

    always_comb begin
        wave  = '0;
        tri_t = {phase[DATA_W-2:0], 1'b0};
        unique case (mode)
            WAVE_SQUARE: wave = phase[DATA_W-1] ? '0 : MAX;
            WAVE_PULSE:  wave = (phase < duty) ? MAX : '0;
            WAVE_SAW:    wave = phase;
            WAVE_TRI:    wave = phase[DATA_W-1] ? ~tri_t : tri_t;
            default:     wave = '0;
        endcase
    end

`ifdef OSC_AMP_SCALE_EN
    logic [2*DATA_W-1:0] product;

    // Keep the high half of the full product: truncating scale, no rounding.
    assign product   = {{DATA_W{1'b0}}, wave} * {{DATA_W{1'b0}}, amplitude};
    assign data_next = product[2*DATA_W-1:DATA_W];
`else
    assign data_next = wave;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
            wrap  <= 1'b0;
            data  <= '0;
        end else begin
            data <= data_next;
            if (sync) begin
                phase <= '0;
                wrap  <= 1'b0;
            end else if (tick) begin
                phase <= phase + DATA_W'(1);
                wrap  <= (phase == MAX);
            end else begin
                wrap  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_waveform_osc.sv
// Self-checking bench for waveform_osc: directed scenarios plus random stimulus against
// a cycle-level arithmetic reference model. Honours OSC_AMP_SCALE_EN.
module tb_waveform_osc;

    localparam int DW   = 8;
    localparam int MAXV = (1 << DW) - 1;
    localparam int HALF = 1 << (DW - 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          sync;
    logic [31:0]   div_max;
    logic [1:0]    mode;
    logic [DW-1:0] duty;
    logic [DW-1:0] amplitude;
    logic [DW-1:0] data;
    logic          wrap;

    int     checks = 0;
    int     errors = 0;
    longint m_cnt  = 0;
    int     m_ph   = 0;
    int     m_data = 0;
    bit     m_wrap = 1'b0;

    always #5 clk = ~clk;

    waveform_osc #(
        .DATA_W (DW),
        .DIV_W  (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sync      (sync),
        .div_max   (div_max),
        .mode      (mode),
        .duty      (duty),
`ifdef OSC_AMP_SCALE_EN
        .amplitude (amplitude),
`endif
        .data      (data),
        .wrap      (wrap)
    );

    function automatic int wave_ref(int ph, int md, int dt);
        case (md)
            0:       return (ph < HALF) ? MAXV : 0;
            1:       return (ph < dt) ? MAXV : 0;
            2:       return ph;
            default: return (ph < HALF) ? 2 * ph : 2 * (MAXV - ph) + 1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus: advance the model from the pre-edge inputs, then compare.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            int nd;
            int ph0;
            int md0;
            int amp0;
            bit rst0;
            ph0  = m_ph;
            md0  = int'(mode);
            amp0 = int'(amplitude);
            rst0 = rst;
            nd   = wave_ref(m_ph, int'(mode), int'(duty));
`ifdef OSC_AMP_SCALE_EN
            nd = (nd * int'(amplitude)) >> DW;
`endif
            if (rst) begin
                m_cnt = 0; m_ph = 0; m_wrap = 1'b0; m_data = 0;
            end else begin
                m_data = nd;
                if (sync) begin
                    m_cnt = 0; m_ph = 0; m_wrap = 1'b0;
                end else if (en && m_cnt >= longint'(div_max)) begin
                    m_cnt  = 0;
                    m_wrap = (m_ph == MAXV);
                    m_ph   = (m_ph + 1) % (MAXV + 1);
                end else begin
                    m_wrap = 1'b0;
                    if (en) m_cnt++;
                end
            end
            @(posedge clk);
            #1;
            chk("data", 32'(data), 32'(m_data));
            chk("wrap", 32'(wrap), 32'(m_wrap));
`ifndef OSC_AMP_SCALE_EN
            if (!rst0 && md0 == 3) begin
                case (ph0)
                    'h00: chk("tri_00", 32'(data), 32'h00);
                    'h7F: chk("tri_7f", 32'(data), 32'hFE);
                    'h80: chk("tri_80", 32'(data), 32'hFF);
                    'hFF: chk("tri_ff", 32'(data), 32'h01);
                    default: ;
                endcase
            end
`else
            if (!rst0 && md0 == 2 && ph0 == 'hFF && amp0 == 'h80) chk("amp_80_ff", 32'(data), 32'h7F);
            if (!rst0 && amp0 == 0) chk("amp_zero", 32'(data), 32'h00);
`endif
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sync = 1'b0; div_max = 0; mode = 2'd0; duty = 0;
        amplitude = 8'hFF;
        step(2);
        chk("reset_data", 32'(data), 32'h0);
        chk("reset_wrap", 32'(wrap), 32'h0);

        // Square, tick every cycle.
        rst = 1'b0; en = 1'b1;
        step(600);

        // Saw at div_max=3, then freeze.
        mode = 2'd2; div_max = 3; sync = 1'b1; step(1); sync = 1'b0;
        step(1100);
        en = 1'b0; step(20);
        en = 1'b1; step(10);

        // Pulse with duty changes, including duty=0 and a mid-period change.
        mode = 2'd1; duty = 8'h40; div_max = 0; sync = 1'b1; step(1); sync = 1'b0;
        step(300);
        duty = 8'h00; step(300);
        duty = 8'h40; step(20);
        duty = 8'hC0; step(250);

        // Triangle.
        mode = 2'd3; sync = 1'b1; step(1); sync = 1'b0;
        step(300);

        // sync at div_cnt=2 / phase=5A, then div_max lowered below a running count.
        mode = 2'd2; div_max = 0; sync = 1'b1; step(1); sync = 1'b0;
        step('h5A);
        div_max = 10; step(2);
        sync = 1'b1; step(1); sync = 1'b0;
        step(3);
        sync = 1'b1; step(1); sync = 1'b0;
        step(7);
        div_max = 2; step(5);

`ifdef OSC_AMP_SCALE_EN
        amplitude = 8'h80; mode = 2'd2; div_max = 0; sync = 1'b1; step(1); sync = 1'b0;
        step(300);
        amplitude = 8'h00; step(20);
        amplitude = 8'(($urandom));
        step(50);
        rst = 1'b1; step(2); rst = 1'b0;
`endif

        // Random stimulus.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                mode    = 2'($urandom_range(0, 3));
                duty    = 8'($urandom);
                div_max = 32'($urandom_range(0, 4));
                amplitude = 8'($urandom);
            end
            en   = ($urandom_range(0, 7) != 0);
            sync = ($urandom_range(0, 63) == 0);
            rst  = ($urandom_range(0, 499) == 0);
            step(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
